num_parse_arbiter: RTL and testbench
====================================

Name: num_parse_arbiter

Overview:
- Shares one ASCII decimal string-to-number parser among N_SRC independent byte streams.
- Grants one source per whole number: it forwards that source's bytes to the parser until the terminating delimiter, then collects the parser's 32-bit result and returns it tagged with the source index.
- Round-robin fairness between sources; the grant is held from first byte through result delivery.

Parameters:
- N_SRC, 4, number of requesting byte streams (2..8)
- SRC_W, 2, width of source index; must satisfy 2**SRC_W >= N_SRC
- TIMEOUT, 255, idle-cycle limit before the grant is dropped (used only with NUM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_dtm  in  8*N_SRC  source bytes; source i occupies bits [8i+7:8i]
- s_vld  in  N_SRC  per-source byte valid
- s_rdy  out  N_SRC  per-source byte ready
- p_dtm  out  8  byte to parser
- p_vld  out  1  byte valid to parser
- p_rdy  in  1  parser byte ready
- q_dtm  in  32  parser result
- q_vld  in  1  parser result valid
- q_rdy  out  1  result ready to parser
- n_dtm  out  32  registered result to consumer
- n_src  out  SRC_W  index of the source that produced n_dtm
- n_vld  out  1  result valid
- n_rdy  in  1  consumer ready
- busy  out  1  high in any state other than IDLE

Behaviour:
- Digit means a byte in "0".."9"; any other byte is a delimiter. Handshake means vld && rdy in the same cycle.
- Reset (async assert, release synchronous to clk):
  - state=IDLE, rr_ptr=0, grant=0, seen_digit=0.
  - n_dtm=0, n_src=0, n_vld=0, busy=0, all s_rdy=0, p_vld=0.
- IDLE:
  - s_rdy=0, p_vld=0, q_rdy=1. Any q_vld here is a stale result (e.g. parser not reset with us); it is consumed and discarded.
  - If any s_vld is high, grant <= first index at or after rr_ptr (cyclic) with s_vld=1; go to FEED. This is one cycle of arbitration latency.
- FEED:
  - p_dtm=s_dtm[grant], p_vld=s_vld[grant], s_rdy[grant]=p_rdy; all other s_rdy=0; q_rdy=0. All three are combinational pass-through.
  - A digit handshake sets seen_digit.
  - A delimiter handshake with seen_digit=0 is forwarded; the parser discards it and the grant is retained.
  - A delimiter handshake with seen_digit=1 goes to WAIT_NUM. The delimiter itself is delivered to the parser.
- WAIT_NUM:
  - p_vld=0, s_rdy=0, q_rdy=1.
  - On q_vld: n_dtm <= q_dtm, n_src <= grant, n_vld <= 1; go to SEND.
- SEND:
  - n_vld=1, q_rdy=0, s_rdy=0.
  - On n_rdy: n_vld <= 0, seen_digit <= 0, rr_ptr <= (grant+1) mod N_SRC; go to IDLE.
- Minimum per-number overhead is 1 arbitration cycle plus 1 capture cycle.
- Simultaneous requests resolve strictly by rr_ptr order. A source that drops s_vld in IDLE is not granted.
- n_dtm and n_src hold their value after delivery until the next capture.
- Reset mid-FEED leaves partial digits inside the parser. This is not recovered (parser has no reset); system reset must cover both blocks. The stale-result flush covers the parser-held-in-send case.
- Overflow is the parser's concern: 32-bit wrap is passed through unchanged.

Optional Feature:
- Macro: NUM_ARB_TIMEOUT_EN.
- Defined:
  - In FEED with seen_digit=0, a counter increments each cycle s_vld[grant]=0 and clears on any handshake.
  - On reaching TIMEOUT: go to IDLE, rr_ptr <= grant+1. No result is produced.
  - With seen_digit=1 the timeout never fires, because the parser holds partial state.
- Undefined: no counter; the grant is held indefinitely until the delimiter.

Test Plan:
- Source 1 sends "123," with others idle -> p_dtm sequence "1","2","3",","; then n_dtm=123, n_src=1, n_vld held until n_rdy.
- Sources 0 and 2 request together, rr_ptr=0, each sends "7;" -> results n_src=0 (value 7) then n_src=2 (value 7); source 2 s_rdy=0 throughout source 0's transaction.
- Source 3 sends "  45\n" (leading spaces) -> spaces forwarded with grant kept; result 45, n_src=3.
- n_rdy held low 10 cycles in SEND -> n_vld stays 1, all s_rdy=0, q_rdy=0; completes on first n_rdy cycle.
- rst_n pulsed mid-WAIT_NUM with q_vld then high -> outputs zeroed immediately; in IDLE q_rdy=1 absorbs the stale result, n_vld stays 0.
- With NUM_ARB_TIMEOUT_EN and TIMEOUT=4: source 0 granted after sending " " then stalls -> returns to IDLE after 4 idle cycles; pending source 1 is granted next.

Source files
------------

// File: rtl/num_parse_arbiter.sv
// num_parse_arbiter: shares one ASCII decimal parser among N_SRC byte streams.
// A source holds the grant from its first byte until its number has been
// handed to the consumer. Grants rotate round-robin.
// Optional build macro NUM_ARB_TIMEOUT_EN: drops a grant that has sent no
// digit and has been idle for TIMEOUT cycles.
module num_parse_arbiter #(
  parameter int N_SRC   = 4,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*N_SRC-1:0] s_dtm,
  input  logic [N_SRC-1:0]   s_vld,
  output logic [N_SRC-1:0]   s_rdy,
  output logic [7:0]         p_dtm,
  output logic               p_vld,
  input  logic               p_rdy,
  input  logic [31:0]        q_dtm,
  input  logic               q_vld,
  output logic               q_rdy,
  output logic [31:0]        n_dtm,
  output logic [SRC_W-1:0]   n_src,
  output logic               n_vld,
  input  logic               n_rdy,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, FEED, WAIT_NUM, SEND} state_t;

  state_t                      state, state_nxt;
  logic [SRC_W-1:0]            rr_ptr, rr_nxt, grant, grant_nxt, grant_inc, arb_idx;
  logic                        seen_digit, seen_nxt, arb_hit;
  logic [N_SRC-1:0][7:0]       src_b;
  logic [7:0]                  cur_b;
  logic                        cur_vld, cur_digit, hs;

  assign src_b     = s_dtm;
  assign cur_b     = src_b[grant];
  assign cur_vld   = s_vld[grant];
  assign cur_digit = (cur_b >= 8'h30) && (cur_b <= 8'h39);
  assign hs        = (state == FEED) && cur_vld && p_rdy;
  assign grant_inc = (grant == SRC_W'(N_SRC - 1)) ? '0 : grant + 1'b1;
  assign p_dtm     = cur_b;
  assign busy      = (state != IDLE);

`ifdef NUM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_fire;

  // Only an empty grant may time out; after a digit the parser holds state.
  assign to_fire = (state == FEED) && !seen_digit && !cur_vld &&
                   (to_cnt == TO_W'(TIMEOUT - 1));

  // Idle-cycle counter for the current digit-less grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           to_cnt <= '0;
    else if (state != FEED || seen_digit) to_cnt <= '0;
    else if (hs || to_fire)               to_cnt <= '0;
    else if (!cur_vld)                    to_cnt <= to_cnt + 1'b1;
  end
`endif

  // Round-robin pick: nearest requester at or after rr_ptr. Scanning from the
  // farthest offset down lets the nearest one win the last assignment.
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] idx_s;
    arb_hit = 1'b0;
    arb_idx = rr_ptr;
    idx     = 0;
    idx_s   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx   = (int'(rr_ptr) + i) % N_SRC;
      idx_s = SRC_W'(idx);
      if (s_vld[idx_s]) begin
        arb_hit = 1'b1;
        arb_idx = idx_s;
      end
    end
  end

  // Next-state and handshake steering.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant;
    seen_nxt  = seen_digit;
    s_rdy     = '0;
    p_vld     = 1'b0;
    q_rdy     = 1'b0;
    case (state)
      IDLE: begin
        q_rdy = 1'b1;  // flush any stale parser result
        if (arb_hit) begin
          grant_nxt = arb_idx;
          state_nxt = FEED;
        end
      end
      FEED: begin
        p_vld        = cur_vld;
        s_rdy[grant] = p_rdy;
        if (hs) begin
          if (cur_digit)       seen_nxt  = 1'b1;
          else if (seen_digit) state_nxt = WAIT_NUM;
        end
`ifdef NUM_ARB_TIMEOUT_EN
        if (to_fire) begin
          state_nxt = IDLE;
          rr_nxt    = grant_inc;
        end
`endif
      end
      WAIT_NUM: begin
        q_rdy = 1'b1;
        if (q_vld) state_nxt = SEND;
      end
      SEND: begin
        if (n_rdy) begin
          state_nxt = IDLE;
          seen_nxt  = 1'b0;
          rr_nxt    = grant_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      seen_digit <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      grant      <= grant_nxt;
      seen_digit <= seen_nxt;
    end
  end

  // Result register: captured from the parser, held after delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_dtm <= '0;
      n_src <= '0;
      n_vld <= 1'b0;
    end else if (state == WAIT_NUM && q_vld) begin
      n_dtm <= q_dtm;
      n_src <= grant;
      n_vld <= 1'b1;
    end else if (state == SEND && n_rdy) begin
      n_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_num_parse_arbiter.sv
// Bench for num_parse_arbiter: behavioural parser model, result scoreboard.
module tb_num_parse_arbiter;
  localparam int N  = 4;
  localparam int SW = 2;
`ifdef NUM_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*N-1:0] s_dtm;
  logic [N-1:0]   s_vld;
  logic [N-1:0]   s_rdy;
  logic [7:0]     p_dtm;
  logic           p_vld;
  logic           p_rdy;
  logic [31:0]    q_dtm;
  logic           q_vld;
  logic           q_rdy;
  logic [31:0]    n_dtm;
  logic [SW-1:0]  n_src;
  logic           n_vld;
  logic           n_rdy;
  logic           busy;

  typedef struct {
    logic [SW-1:0] src;
    logic [31:0]   val;
  } exp_t;

  exp_t sb[$];
  byte  p_log[$];
  int   pass_cnt     = 0;
  int   total_cnt    = 0;
  int   results_seen = 0;
  int   q_delay      = 3;

  num_parse_arbiter #(.N_SRC(N), .SRC_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_dtm(s_dtm), .s_vld(s_vld), .s_rdy(s_rdy),
    .p_dtm(p_dtm), .p_vld(p_vld), .p_rdy(p_rdy),
    .q_dtm(q_dtm), .q_vld(q_vld), .q_rdy(q_rdy),
    .n_dtm(n_dtm), .n_src(n_src), .n_vld(n_vld), .n_rdy(n_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Parser model: accumulates digits, emits result q_delay cycles after a
  // delimiter that followed digits; it has no reset, like the real parser.
  logic [31:0] acc = '0, res = '0;
  logic        have = 1'b0;
  int          dly_cnt = 0;
  initial begin q_vld = 1'b0; q_dtm = '0; end
  always @(posedge clk) begin
    if (q_vld && q_rdy) q_vld <= 1'b0;
    if (dly_cnt != 0) begin
      dly_cnt <= dly_cnt - 1;
      if (dly_cnt == 1) begin q_vld <= 1'b1; q_dtm <= res; end
    end
    if (p_vld && p_rdy) begin
      p_log.push_back(p_dtm);
      if (p_dtm >= 8'h30 && p_dtm <= 8'h39) begin
        acc  <= acc * 32'd10 + {24'd0, p_dtm - 8'h30};
        have <= 1'b1;
      end else if (have) begin
        res     <= acc;
        acc     <= '0;
        have    <= 1'b0;
        dly_cnt <= q_delay;
      end
    end
  end

  // Result monitor: pops the scoreboard on every consumer handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && n_vld && n_rdy) begin
      results_seen++;
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL result_unexpected got src=%0d val=%0d expected none", n_src, n_dtm);
      end else begin
        e = sb.pop_front();
        if (n_src !== e.src || n_dtm !== e.val)
          $display("FAIL result got src=%0d val=%0d expected src=%0d val=%0d",
                   n_src, n_dtm, e.src, e.val);
        else pass_cnt++;
      end
    end
  end

  task automatic send_str(input int src, input string s);
    int w;
    for (int i = 0; i < s.len(); i++) begin
      w = 0;
      s_dtm[src*8 +: 8] = s[i];
      s_vld[src] = 1'b1;
      @(negedge clk);
      while (!s_rdy[src] && w < 200) begin @(negedge clk); w++; end
      if (!s_rdy[src]) begin
        total_cnt++;
        $display("FAIL send_timeout src=%0d byte=%0d got s_rdy=0 expected 1", src, i);
        s_vld[src] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_vld[src] = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int w;
    w = 0;
    while (results_seen < n && w < 500) begin @(negedge clk); w++; end
    total_cnt++;
    if (results_seen < n) $display("FAIL wait_results got %0d expected %0d", results_seen, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_dtm = '0; s_vld = '0; p_rdy = 1'b1; n_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (n_dtm !== 32'd0) $display("FAIL rst_n_dtm got %0d expected 0", n_dtm); else pass_cnt++;
    total_cnt++; if (n_src !== '0) $display("FAIL rst_n_src got %0d expected 0", n_src); else pass_cnt++;
    total_cnt++; if (n_vld !== 1'b0) $display("FAIL rst_n_vld got %b expected 0", n_vld); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (s_rdy !== '0) $display("FAIL rst_s_rdy got %b expected 0", s_rdy); else pass_cnt++;
    total_cnt++; if (p_vld !== 1'b0) $display("FAIL rst_p_vld got %b expected 0", p_vld); else pass_cnt++;
    total_cnt++; if (q_rdy !== 1'b1) $display("FAIL rst_q_rdy got %b expected 1", q_rdy); else pass_cnt++;
  endtask

  // rr_ptr is 0 here: source 0 first, source 2 locked out until delivery.
  task automatic test_rr();
    int  base;
    base = results_seen;
    sb.push_back('{src: 2'd0, val: 32'd7});
    sb.push_back('{src: 2'd2, val: 32'd7});
    fork
      send_str(0, "7;");
      send_str(2, "7;");
      begin
        int  c;
        bit  bad;
        c = 0; bad = 1'b0;
        while (results_seen < base + 1 && c < 500) begin
          @(negedge clk);
          if (s_rdy[2]) bad = 1'b1;
          c++;
        end
        total_cnt++;
        if (bad || results_seen < base + 1)
          $display("FAIL rr_lockout got s_rdy2_seen=%b expected 0", bad);
        else pass_cnt++;
      end
    join
    wait_results(base + 2);
  endtask

  // Source 1 "123," with n_rdy held low for 10 cycles while source 2 waits.
  task automatic test_hold();
    int    base, w;
    string exp_s;
    bit    bad;
    base = results_seen; exp_s = "123,";
    n_rdy = 1'b0;
    p_log.delete();
    sb.push_back('{src: 2'd1, val: 32'd123});
    sb.push_back('{src: 2'd2, val: 32'd8});
    fork
      send_str(1, "123,");
      send_str(2, "8,");
    join_none
    w = 0;
    while (!n_vld && w < 500) begin @(negedge clk); w++; end
    total_cnt++;
    if (!n_vld) $display("FAIL hold_nvld_rise got 0 expected 1"); else pass_cnt++;
    bad = (p_log.size() != exp_s.len());
    for (int i = 0; i < p_log.size() && !bad; i++) if (p_log[i] != exp_s[i]) bad = 1'b1;
    total_cnt++;
    if (bad) $display("FAIL hold_p_seq got %0d bytes expected \"123,\"", p_log.size());
    else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total_cnt++;
      if (n_vld !== 1'b1 || s_rdy !== '0 || q_rdy !== 1'b0 || n_dtm !== 32'd123 || n_src !== 2'd1)
        $display("FAIL hold_cycle%0d got vld=%b s_rdy=%b q_rdy=%b val=%0d src=%0d expected 1 0000 0 123 1",
                 k, n_vld, s_rdy, q_rdy, n_dtm, n_src);
      else pass_cnt++;
    end
    @(posedge clk); #1; n_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (n_vld !== 1'b0) $display("FAIL hold_release got n_vld=%b expected 0", n_vld); else pass_cnt++;
    wait fork;
    wait_results(base + 2);
  endtask

  // Leading spaces are forwarded under the same grant; p_rdy jitters.
  task automatic test_spaces();
    int    base;
    string exp_s;
    bit    bad, stop;
    base = results_seen; exp_s = "  45\n"; stop = 1'b0;
    p_log.delete();
    sb.push_back('{src: 2'd3, val: 32'd45});
    fork
      begin send_str(3, exp_s); stop = 1'b1; end
      while (!stop) begin @(posedge clk); #1; p_rdy = 1'($urandom_range(0, 1)); end
    join
    p_rdy = 1'b1;
    wait_results(base + 1);
    bad = (p_log.size() != exp_s.len());
    for (int i = 0; i < p_log.size() && !bad; i++) if (p_log[i] != exp_s[i]) bad = 1'b1;
    total_cnt++;
    if (bad) $display("FAIL spaces_p_seq got %0d bytes expected 5", p_log.size()); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (n_dtm !== 32'd45 || n_src !== 2'd3 || n_vld !== 1'b0)
      $display("FAIL result_hold got val=%0d src=%0d vld=%b expected 45 3 0", n_dtm, n_src, n_vld);
    else pass_cnt++;
  endtask

  // 4294967297 wraps to 1 in the parser; passed through unchanged.
  task automatic test_overflow();
    int base;
    base = results_seen;
    sb.push_back('{src: 2'd0, val: 32'd1});
    send_str(0, "4294967297,");
    wait_results(base + 1);
  endtask

  // Reset in WAIT_NUM; the late parser result must be flushed in IDLE.
  task automatic test_stale_flush();
    int w;
    q_delay = 6;
    send_str(1, "9,");
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL flush_busy got %b expected 1", busy); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (n_vld !== 1'b0 || n_dtm !== 32'd0 || n_src !== '0 || busy !== 1'b0 || s_rdy !== '0 || p_vld !== 1'b0)
      $display("FAIL midreset got vld=%b val=%0d src=%0d busy=%b s_rdy=%b p_vld=%b expected all 0",
               n_vld, n_dtm, n_src, busy, s_rdy, p_vld);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    w = 0;
    while (!q_vld && w < 50) begin @(negedge clk); w++; end
    total_cnt++;
    if (q_vld !== 1'b1 || q_rdy !== 1'b1)
      $display("FAIL stale_q got q_vld=%b q_rdy=%b expected 1 1", q_vld, q_rdy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (q_vld !== 1'b0 || n_vld !== 1'b0 || busy !== 1'b0)
      $display("FAIL stale_drop got q_vld=%b n_vld=%b busy=%b expected 0 0 0", q_vld, n_vld, busy);
    else pass_cnt++;
    q_delay = 3;
  endtask

`ifdef NUM_ARB_TIMEOUT_EN
  // Source 0 sends one space then stalls; grant drops after 4 idle cycles.
  task automatic test_timeout();
    int base;
    base = results_seen;
    sb.push_back('{src: 2'd1, val: 32'd6});
    send_str(0, " ");
    fork
      send_str(1, "6,");
    join_none
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b1 || s_rdy[1] !== 1'b0)
        $display("FAIL to_hold%0d got busy=%b s_rdy1=%b expected 1 0", k, busy, s_rdy[1]);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL to_fire got busy=%b expected 0", busy); else pass_cnt++;
    wait fork;
    wait_results(base + 1);
  endtask
`endif

  initial begin
    test_reset();
    test_rr();
    test_hold();
    test_spaces();
    test_overflow();
    test_stale_flush();
`ifdef NUM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(negedge clk);
    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_drain got %0d expected 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
